// File: rtl/mips8_pkg.sv
// Shared constants and types for the 8-bit MIPS-subset core.
package mips8_pkg;

    localparam int WIDTH   = 8;
    localparam int REGBITS = 3;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_ctl_t;

endpackage

// File: rtl/mips8_if.sv
// Harvard memory bus: instruction fetch port plus byte load/store port.
interface mips8_if;
    import mips8_pkg::*;

    logic [WIDTH-1:0] i_addr;
    logic [31:0]      i;
    logic [WIDTH-1:0] rw_addr;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] w;
    logic             w_en;

    modport master (
        output i_addr, rw_addr, w, w_en,
        input  i, r
    );

    modport slave (
        input  i_addr, rw_addr, w, w_en,
        output i, r
    );

endinterface

// File: rtl/mips8_alu.sv
// Combinational ALU; SLT is an unsigned compare.
module mips8_alu
    import mips8_pkg::*;
#(
    parameter int WIDTH = mips8_pkg::WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_ctl_t         ctl,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    always_comb begin
        result = '0;
        unique case (ctl)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_SLT: result = (a < b) ? WIDTH'(1) : '0;
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/mips8_core.sv
// Single-cycle 8-bit MIPS subset: register file, decoder and PC logic.
module mips8_core
    import mips8_pkg::*;
#(
    parameter int WIDTH   = mips8_pkg::WIDTH,
    parameter int REGBITS = mips8_pkg::REGBITS
) (
    input  logic     clk,
    input  logic     rst,
    mips8_if.master  bus
);

    logic [31:0]        instr;
    logic [5:0]         op;
    logic [5:0]         funct;
    logic [REGBITS-1:0] rs;
    logic [REGBITS-1:0] rt;
    logic [REGBITS-1:0] rd;
    logic [WIDTH-1:0]   imm_x;

    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] pc_br;
    logic [WIDTH-1:0] pc_jmp;
    logic [WIDTH-1:0] pc_next;

    logic [WIDTH-1:0] regs [2**REGBITS];
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic [WIDTH-1:0] wdata;

    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_y;
    logic             alu_zero;

    logic               reg_we;
    logic [REGBITS-1:0] dst;
    logic               use_imm;
    logic               mem_to_reg;
    logic               store;
    logic               branch;
    logic               jump;
    alu_ctl_t           ctl;

    logic unused;

    assign instr = bus.i;
    assign op    = instr[31:26];
    assign funct = instr[5:0];
    assign rs    = instr[21 +: REGBITS];
    assign rt    = instr[16 +: REGBITS];
    assign rd    = instr[11 +: REGBITS];
    assign imm_x = WIDTH'($signed(instr[7:0]));

    assign unused = ^{instr[25:24], instr[20:19],
                      instr[15:14], instr[10:8]};

    // Unrecognised opcodes and functs keep every default: a NOP.
    always_comb begin
        reg_we     = 1'b0;
        dst        = rt;
        use_imm    = 1'b0;
        mem_to_reg = 1'b0;
        store      = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        ctl        = ALU_ADD;
        unique case (1'b1)
            (op == OP_RTYPE): begin
                dst = rd;
                unique case (funct)
                    FN_ADD: begin reg_we = 1'b1; ctl = ALU_ADD; end
                    FN_SUB: begin reg_we = 1'b1; ctl = ALU_SUB; end
                    FN_AND: begin reg_we = 1'b1; ctl = ALU_AND; end
                    FN_OR:  begin reg_we = 1'b1; ctl = ALU_OR;  end
                    FN_SLT: begin reg_we = 1'b1; ctl = ALU_SLT; end
                    default: reg_we = 1'b0;
                endcase
            end
            (op == OP_ADDI): begin
                reg_we  = 1'b1;
                use_imm = 1'b1;
            end
            (op == OP_LB): begin
                reg_we     = 1'b1;
                mem_to_reg = 1'b1;
            end
            (op == OP_SB):  store  = 1'b1;
            (op == OP_BEQ): begin
                branch = 1'b1;
                ctl    = ALU_SUB;
            end
            (op == OP_J):   jump   = 1'b1;
            default:        reg_we = 1'b0;
        endcase
    end

    assign rs_val = (rs == '0) ? '0 : regs[rs];
    assign rt_val = (rt == '0) ? '0 : regs[rt];
    assign alu_b  = use_imm ? imm_x : rt_val;

    mips8_alu #(.WIDTH(WIDTH)) u_alu (
        .a      (rs_val),
        .b      (alu_b),
        .ctl    (ctl),
        .result (alu_y),
        .zero   (alu_zero)
    );

    assign wdata = mem_to_reg ? bus.r : alu_y;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 2**REGBITS; k++)
                regs[k] <= '0;
        end else if (reg_we && dst != '0) begin
            regs[dst] <= wdata;
        end
    end

    assign pc_plus4 = pc + WIDTH'(4);
    assign pc_br    = pc_plus4 + (imm_x << 2);
    assign pc_jmp   = WIDTH'({instr[5:0], 2'b00});

    always_comb begin
        pc_next = pc_plus4;
        if (jump)
            pc_next = pc_jmp;
        else if (branch && alu_zero)
            pc_next = pc_br;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pc <= '0;
        else      pc <= pc_next;
    end

    assign bus.i_addr  = pc;
    assign bus.rw_addr = rs_val + imm_x;
    assign bus.w       = rt_val;
    // Gate with reset so a store in flight never reaches memory.
    assign bus.w_en    = store & rst;

endmodule

// File: tb/tb_mips8_core.sv
// Directed programs with a store scoreboard for mips8_core.
module tb_mips8_core;
    import mips8_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;

    mips8_if bus();

    logic [31:0] imem [64];
    logic [7:0]  dmem [256];
    logic        pre_en = 1'b0;
    logic [7:0]  pre_addr = '0;
    logic [7:0]  pre_data = '0;

    logic [15:0] exp_q [$];
    logic [15:0] e;
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mips8_core dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.i = imem[bus.i_addr[7:2]];
    assign bus.r = dmem[bus.rw_addr];

    always @(posedge clk) begin
        if (pre_en)
            dmem[pre_addr] <= pre_data;
        else if (bus.w_en)
            dmem[bus.rw_addr] <= bus.w;
    end

    always @(negedge clk) begin
        if (rst && bus.w_en) begin
            n_checks++;
            assert (exp_q.size() != 0) else begin
                n_errors++;
                $error("FAIL store_unexpected got %02h@%02h",
                       bus.w, bus.rw_addr);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_checks++;
                assert ({bus.rw_addr, bus.w} === e) else begin
                    n_errors++;
                    $error("FAIL store got %02h@%02h expected %02h@%02h",
                           bus.w, bus.rw_addr, e[7:0], e[15:8]);
                end
            end
        end
    end

    function automatic logic [31:0] rtype(input logic [2:0] rs,
        input logic [2:0] rt, input logic [2:0] rd, input logic [5:0] fn);
        return {OP_RTYPE, 2'b00, rs, 2'b00, rt, 2'b00, rd, 5'b0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op,
        input logic [2:0] rs, input logic [2:0] rt, input logic [7:0] imm);
        return {op, 2'b00, rs, 2'b00, rt, 8'h00, imm};
    endfunction

    function automatic logic [31:0] jtype(input logic [5:0] t);
        return {OP_J, 20'b0, t};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_imem();
        for (int k = 0; k < 64; k++) imem[k] = 32'h0;
    endtask

    task automatic enter_reset();
        @(negedge clk);
        rst = 1'b0;
        clear_imem();
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        pre_addr = a;
        pre_data = d;
        pre_en   = 1'b1;
        @(negedge clk);
        pre_en   = 1'b0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        for (int k = 0; k < 256; k++) dmem[k] = 8'h00;
        clear_imem();

        // Reset and ADDI/SB
        enter_reset();
        imem[0] = itype(OP_ADDI, 3'd0, 3'd1, 8'd5);
        imem[1] = itype(OP_SB,   3'd0, 3'd1, 8'hFF);
        imem[2] = jtype(6'd2);
        @(negedge clk);
        chk("reset_i_addr", 32'(bus.i_addr), 32'h0);
        chk("reset_w_en",   32'(bus.w_en),   32'h0);
        exp_q.push_back({8'hFF, 8'd5});
        release_reset();
        chk("fetch0", 32'(bus.i_addr), 32'h0);
        chk("pre_store_w_en", 32'(bus.w_en), 32'h0);
        cycles(1);
        chk("fetch4", 32'(bus.i_addr), 32'h4);
        cycles(1);
        chk("fetch8", 32'(bus.i_addr), 32'h8);
        cycles(2);
        chk("dmem255", 32'(dmem[255]), 32'd5);
        chk("q_empty_addi", 32'(exp_q.size()), 32'h0);

        // Reset landing on the store cycle
        enter_reset();
        imem[0] = itype(OP_ADDI, 3'd0, 3'd1, 8'd5);
        imem[1] = itype(OP_SB,   3'd0, 3'd1, 8'hFF);
        imem[2] = jtype(6'd2);
        release_reset();
        @(posedge clk);
        #1;
        chk("sb_w_en_live", 32'(bus.w_en), 32'h1);
        rst = 1'b0;
        #1;
        chk("mid_reset_w_en",   32'(bus.w_en),   32'h0);
        chk("mid_reset_i_addr", 32'(bus.i_addr), 32'h0);
        exp_q.push_back({8'hFF, 8'd5});
        release_reset();
        cycles(4);
        chk("q_empty_restart", 32'(exp_q.size()), 32'h0);

        // R-type and SLT
        enter_reset();
        imem[0]  = itype(OP_ADDI, 3'd0, 3'd1, 8'd7);
        imem[1]  = itype(OP_ADDI, 3'd0, 3'd2, 8'd3);
        imem[2]  = rtype(3'd1, 3'd2, 3'd3, FN_ADD);
        imem[3]  = itype(OP_SB, 3'd0, 3'd3, 8'h10);
        imem[4]  = rtype(3'd1, 3'd2, 3'd4, FN_SUB);
        imem[5]  = itype(OP_SB, 3'd0, 3'd4, 8'h10);
        imem[6]  = rtype(3'd1, 3'd2, 3'd5, FN_AND);
        imem[7]  = itype(OP_SB, 3'd0, 3'd5, 8'h10);
        imem[8]  = rtype(3'd1, 3'd2, 3'd6, FN_OR);
        imem[9]  = itype(OP_SB, 3'd0, 3'd6, 8'h10);
        imem[10] = rtype(3'd2, 3'd1, 3'd7, FN_SLT);
        imem[11] = itype(OP_SB, 3'd0, 3'd7, 8'h10);
        imem[12] = rtype(3'd1, 3'd2, 3'd7, FN_SLT);
        imem[13] = itype(OP_SB, 3'd0, 3'd7, 8'h10);
        imem[14] = rtype(3'd1, 3'd2, 3'd3, 6'b111111);
        imem[15] = itype(OP_SB, 3'd0, 3'd3, 8'h11);
        imem[16] = jtype(6'd16);
        exp_q.push_back({8'h10, 8'd10});
        exp_q.push_back({8'h10, 8'd4});
        exp_q.push_back({8'h10, 8'd3});
        exp_q.push_back({8'h10, 8'd7});
        exp_q.push_back({8'h10, 8'd1});
        exp_q.push_back({8'h10, 8'd0});
        exp_q.push_back({8'h11, 8'd10});
        release_reset();
        cycles(20);
        chk("q_empty_rtype", 32'(exp_q.size()), 32'h0);

        // LB and BEQ
        enter_reset();
        preload(8'h20, 8'd9);
        imem[0] = itype(OP_LB,   3'd0, 3'd1, 8'h20);
        imem[1] = itype(OP_SB,   3'd0, 3'd1, 8'h30);
        imem[2] = itype(OP_ADDI, 3'd0, 3'd2, 8'd9);
        imem[3] = itype(OP_BEQ,  3'd1, 3'd2, 8'd1);
        imem[4] = itype(OP_ADDI, 3'd0, 3'd3, 8'h55);
        imem[5] = itype(OP_SB,   3'd0, 3'd3, 8'h31);
        imem[6] = itype(OP_BEQ,  3'd1, 3'd0, 8'd1);
        imem[7] = itype(OP_ADDI, 3'd0, 3'd4, 8'h66);
        imem[8] = itype(OP_SB,   3'd0, 3'd4, 8'h32);
        imem[9] = jtype(6'd9);
        exp_q.push_back({8'h30, 8'd9});
        exp_q.push_back({8'h31, 8'd0});
        exp_q.push_back({8'h32, 8'h66});
        release_reset();
        cycles(14);
        chk("q_empty_lb_beq", 32'(exp_q.size()), 32'h0);

        // Jump
        enter_reset();
        imem[0] = jtype(6'd3);
        imem[1] = itype(OP_SB, 3'd0, 3'd0, 8'h40);
        imem[2] = itype(OP_SB, 3'd0, 3'd0, 8'h41);
        imem[3] = jtype(6'd3);
        release_reset();
        cycles(1);
        chk("jump_target", 32'(bus.i_addr), 32'd12);
        cycles(3);
        chk("jump_hold", 32'(bus.i_addr), 32'd12);

        // Fibonacci
        enter_reset();
        imem[0]  = itype(OP_ADDI, 3'd0, 3'd1, 8'd0);
        imem[1]  = itype(OP_ADDI, 3'd0, 3'd2, 8'd1);
        imem[2]  = itype(OP_ADDI, 3'd0, 3'd3, 8'd7);
        imem[3]  = itype(OP_BEQ,  3'd3, 3'd0, 8'd5);
        imem[4]  = rtype(3'd1, 3'd2, 3'd5, FN_ADD);
        imem[5]  = itype(OP_ADDI, 3'd2, 3'd1, 8'd0);
        imem[6]  = itype(OP_ADDI, 3'd5, 3'd2, 8'd0);
        imem[7]  = itype(OP_ADDI, 3'd3, 3'd3, 8'hFF);
        imem[8]  = jtype(6'd3);
        imem[9]  = itype(OP_SB, 3'd0, 3'd1, 8'hFF);
        imem[10] = jtype(6'd10);
        exp_q.push_back({8'hFF, 8'd13});
        release_reset();
        cycles(200);
        chk("fib_done", 32'(exp_q.size()), 32'h0);
        chk("fib_halt", 32'(bus.i_addr), 32'd40);

        // r0 and modulo arithmetic
        enter_reset();
        imem[0] = itype(OP_ADDI, 3'd0, 3'd0, 8'd5);
        imem[1] = itype(OP_SB,   3'd0, 3'd0, 8'd1);
        imem[2] = itype(OP_ADDI, 3'd0, 3'd1, 8'hFF);
        imem[3] = itype(OP_ADDI, 3'd1, 3'd1, 8'd2);
        imem[4] = itype(OP_SB,   3'd0, 3'd1, 8'h50);
        imem[5] = itype(OP_SB,   3'd1, 3'd1, 8'hFF);
        imem[6] = jtype(6'd6);
        exp_q.push_back({8'h01, 8'd0});
        exp_q.push_back({8'h50, 8'd1});
        exp_q.push_back({8'h00, 8'd1});
        release_reset();
        cycles(10);
        chk("q_empty_r0_wrap", 32'(exp_q.size()), 32'h0);

        // PC wrap through a NOP-only image
        enter_reset();
        release_reset();
        cycles(63);
        chk("pc_252", 32'(bus.i_addr), 32'd252);
        cycles(1);
        chk("pc_wrap", 32'(bus.i_addr), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mips8_core.md
Name: mips8_core

Overview:
- 8-bit single-cycle MIPS-subset processor with separate instruction and data ports (Harvard style).
- Fetches 32-bit instructions from an external memory and loads/stores bytes through a separate 8-bit data port.
- Sits between the external code/data memory and the system bench.
- Runs programs such as the Fibonacci kernel, which ends with a single store of the result 13 to address 255.

Parameters:
- WIDTH, 8, datapath/register/address width
- REGBITS, 3, register index bits (8 registers)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-low
- i_addr  out  8  instruction byte address (= PC)
- i  in  32  instruction word, combinationally valid for the current i_addr
- rw_addr  out  8  data byte address (rs + sign-extended imm[7:0])
- r  in  8  read data, combinationally valid for rw_addr
- w  out  8  store data (register rt)
- w_en  out  1  store strobe; memory writes w at rw_addr on the next rising clk

Behaviour:
- Reset (rst low, asynchronous):
  - PC=0; all registers=0.
  - w_en forced to 0 while rst is low.
  - i_addr=0.
- Execution is CPI=1: each rising clk retires the instruction addressed by PC. No stalls, no pipeline.
- Fields:
  - op=i[31:26], rs=i[23:21], rt=i[18:16], rd=i[13:11] (low 3 bits of the MIPS 5-bit fields).
  - funct=i[5:0]; imm=i[7:0]; jump target = i[5:0].
- Register file:
  - 8x8 bits, 2 combinational read ports, 1 write port written on rising clk.
  - r0 always reads 0; writes to r0 are discarded.
- Instructions:
  - R-type op 000000. funct 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT. Result goes to rd.
  - SLT is unsigned 8-bit compare, result 1 or 0.
  - ADDI op 001000: rt <= rs+imm.
  - LB op 100000: rt <= r, with rw_addr = rs+imm.
  - SB op 101000: w_en=1, w=rt, rw_addr=rs+imm. No register write.
  - BEQ op 000100: if rs==rt then PC <= PC+4+(imm<<2), else PC+4.
  - J op 000010: PC <= {target[5:0],2'b00}.
  - Any other opcode or R-type funct is a NOP: PC+4, no writes, w_en=0.
- Arithmetic: all 8-bit modulo 2^8. No overflow detection. PC wraps 252 -> 0.
- w_en is combinational from the decoded current instruction and is stable before the falling edge of each cycle.
- rw_addr and w are driven for every instruction; they are don't-care when w_en=0 unless LB.
- Reset asserted mid-instruction:
  - The pending register/PC update is lost.
  - w_en drops immediately.
  - Execution restarts at PC=0 after release.

Decomposition:
- Shared package mips8_pkg: opcode constants (OP_RTYPE, OP_ADDI, OP_LB, OP_SB, OP_BEQ, OP_J), funct constants, ALU control enum (ADD, SUB, AND, OR, SLT), WIDTH/REGBITS.
- One sub-module: mips8_alu (8-bit combinational ALU: a, b, ctl -> result, zero).
- Register file, decoder, and PC logic live in mips8_core.

Test Plan:
- Reset: rst low -> i_addr=0 and w_en=0 during reset. After release, first fetch is at address 0 and i_addr advances 0, 4, 8.
- ADDI/SB: program "ADDI r1,r0,5; SB r1,255(r0)" -> in cycle 2, w_en=1, rw_addr=255, w=5. Prior cycle has w_en=0.
- R-type/SLT: r1=7, r2=3.
  - ADD r3 -> 10; SUB r4 -> 4; AND r5 -> 3; OR r6 -> 7.
  - SLT r7,r2,r1 -> 1; SLT r7,r1,r2 -> 0.
  - Each verified by storing to address 0x10.
- LB/BEQ/J:
  - Memory[0x20]=9: LB r1,0x20(r0) -> r1=9.
  - BEQ with equal regs skips the next instruction; with unequal regs it falls through.
  - J 0x03 -> i_addr=12.
- Fibonacci program (loop via BEQ/J, result stored with SB) -> first and only w_en pulse has rw_addr=255, w=13, well within 1000 cycles.
- r0 and wrap: ADDI r0,r0,5 then SB r0,1(r0) -> w=0; ADDI r1,r0,0xFF; ADDI r1,r1,2 -> r1=1.
